// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared constants and state encoding for the register-file write arbiter
// Purpose: register-file geometry and the write-arbiter FSM state type.
// Ports: none (package).
package regfile_ctrl_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first asserted request at or after the pointer, wrapping around.
// Ports:
//   req    in   NREQ    request vector
//   ptr    in   PTR_W   highest-priority index this cycle
//   grant  out  NREQ    one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic found;

  // Outer loop walks the priority order ptr, ptr+1, ...; the inner loop keeps
  // every bit index constant so no variable bit-select is needed.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the single register-file write port
// Purpose: shares W_Addr/W_Data/Write_Reg among NREQ valid/ready requesters, one
//   registered write per cycle; writes to address 0 are consumed but suppressed.
// Optional feature: macro REGFILE_CLEAR_SEQ_EN enables the clear sequence (Clear_Req
//   writes 0 to registers 1..NUM_REGS-1 on consecutive cycles, Clear_Busy meanwhile).
// Ports:
//   CLK, Reset_n   clock, asynchronous active-low reset
//   Req_Valid/Req_Ready/Req_Addr/Req_Data   per-requester handshake, packed slices
//   Grant_Id       index of last accepted requester
//   W_Addr/W_Data/Write_Reg   registered write port to the register stack
//   Clear_Req/Clear_Busy      clear request and clear-in-progress flag
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W,
  parameter int DATA_W = regfile_ctrl_pkg::DATA_W,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     CLK,
  input  logic                     Reset_n,
  input  logic [NREQ-1:0]          Req_Valid,
  output logic [NREQ-1:0]          Req_Ready,
  input  logic [NREQ*ADDR_W-1:0]   Req_Addr,
  input  logic [NREQ*DATA_W-1:0]   Req_Data,
  output logic [ID_W-1:0]          Grant_Id,
  output logic [ADDR_W-1:0]        W_Addr,
  output logic [DATA_W-1:0]        W_Data,
  output logic                     Write_Reg,
  input  logic                     Clear_Req,
  output logic                     Clear_Busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [NREQ-1:0]   grant;
  logic              clear_go;
  logic              arb_en;
  logic              accept;
  logic [ID_W-1:0]   acc_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (ID_W)
  ) u_rr_arbiter (
    .req   (Req_Valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

`ifdef REGFILE_CLEAR_SEQ_EN
  // Clear wins over any simultaneous request; ignored once already clearing.
  assign clear_go = (state_q == ST_IDLE) && Clear_Req;
`else
  logic unused_clear_req;
  assign unused_clear_req = Clear_Req;
  assign clear_go         = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; W_Addr doubles as the clear address counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clear_go) state_d = ST_CLEAR;
`ifdef REGFILE_CLEAR_SEQ_EN
      ST_CLEAR: if (W_Addr == LAST_ADDR) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic; handshake is held off during reset so nothing is consumed then
  always_comb begin
    arb_en    = Reset_n && (state_q == ST_IDLE) && !clear_go;
    Req_Ready = arb_en ? grant : '0;
`ifdef REGFILE_CLEAR_SEQ_EN
    Clear_Busy = (state_q == ST_CLEAR);
`else
    Clear_Busy = 1'b0;
`endif
  end

  always_comb begin
    acc_id   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        acc_id   = ID_W'(i);
        sel_addr = Req_Addr[i*ADDR_W +: ADDR_W];
        sel_data = Req_Data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept = arb_en && (|grant);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Write_Reg <= 1'b0;
      W_Addr    <= '0;
      W_Data    <= '0;
      Grant_Id  <= '0;
      ptr_q     <= '0;
    end else if (clear_go) begin
      Write_Reg <= 1'b1;
      W_Addr    <= ADDR_W'(1);
      W_Data    <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (W_Addr == LAST_ADDR) begin
        Write_Reg <= 1'b0;
      end else begin
        Write_Reg <= 1'b1;
        W_Addr    <= W_Addr + ADDR_W'(1);
      end
    end else if (accept) begin
      // Register 0 is hard-wired: consume the request but suppress the write.
      Write_Reg <= (sel_addr != '0);
      W_Addr    <= sel_addr;
      W_Data    <= sel_data;
      Grant_Id  <= acc_id;
      ptr_q     <= (acc_id == ID_W'(NREQ - 1)) ? '0 : acc_id + ID_W'(1);
    end else begin
      Write_Reg <= 1'b0;
    end
  end

endmodule
